// File: rtl/ddr_cmd_queue.sv
// ddr_cmd_queue: DDR4 address-decoding command FIFO with init hold-off, flow control and per-bank open-row tracking
module ddr_cmd_queue #(
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = 29,
  parameter int DATA_W      = 64,
  parameter int COL_W       = 10,
  parameter int BA_W        = 2,
  parameter int BG_W        = 2,
  parameter int ROW_W       = ADDR_W - COL_W - BA_W - BG_W,
  parameter int INIT_CYCLES = 100
) (
  input  logic                         clock_t,
  input  logic                         reset_t,
  input  logic                         act_cmd,
  input  logic [ADDR_W-1:0]            in_addr,
  input  logic [DATA_W-1:0]            in_data,
  input  logic [1:0]                   in_rw,
  output logic                         next_cmd,
  output logic                         dev_busy,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [1:0]                   cmd_rw,
  output logic [ROW_W-1:0]             cmd_row,
  output logic [BG_W-1:0]              cmd_bg,
  output logic [BA_W-1:0]              cmd_ba,
  output logic [COL_W-1:0]             cmd_col,
  output logic [DATA_W-1:0]            cmd_data,
  output logic                         cmd_row_hit,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         overflow,
  output logic                         bad_op
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int BW = BG_W + BA_W;
  localparam int CW = $clog2(INIT_CYCLES + 1);
  localparam int EW = 2 + ADDR_W + DATA_W;
  typedef enum logic {INIT, RUN} state_t;
  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [PW-1:0]     wr_q, rd_q;
  logic [OW-1:0]     occ_q, occ_d;
  logic              next_cmd_q, dev_busy_q, overflow_q, bad_op_q;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [(1<<BW)-1:0] open_q;
  logic [ROW_W-1:0]  open_row_q [1<<BW];
  logic [EW-1:0]     head;
  logic [BW-1:0]     bank;
  logic              legal, req, pop, push;
  assign cmd_valid = occ_q != '0;
  assign occupancy = occ_q;
  assign next_cmd  = next_cmd_q;
  assign dev_busy  = dev_busy_q;
  assign overflow  = overflow_q;
  assign bad_op    = bad_op_q;
  // address is stored whole: its bit order already is {row, bg, ba, col}
  assign {cmd_rw, cmd_row, cmd_bg, cmd_ba, cmd_col, cmd_data} = head;
  assign bank        = {cmd_bg, cmd_ba};
  assign cmd_row_hit = cmd_valid && open_q[bank] && open_row_q[bank] == cmd_row;
  always_comb begin
    legal = in_rw == 2'b01 || in_rw == 2'b10;
    req   = act_cmd && state_q == RUN;
    pop   = cmd_valid && cmd_ready;
    push  = req && legal && (occ_q != OW'(DEPTH) || pop);
    occ_d = occ_q + OW'(push) - OW'(pop);
    head  = cmd_valid ? mem_q[rd_q] : '0;
  end
  always_ff @(posedge clock_t)
    if (push) mem_q[wr_q] <= {in_rw, in_addr, (in_rw == 2'b10) ? in_data : DATA_W'(0)};
  always_ff @(posedge clock_t) begin
    if (reset_t) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      dev_busy_q <= 1'b1;
      next_cmd_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
      bad_op_q   <= 1'b0;
      open_q     <= '0;
    end else begin
      if (state_q == INIT) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CW'(INIT_CYCLES - 1)) begin
          state_q    <= RUN;
          dev_busy_q <= 1'b0;
        end
      end
      next_cmd_q <= state_q == RUN && occ_d <= OW'(DEPTH - 2);
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) begin
        rd_q             <= rd_q + 1'b1;
        open_q[bank]     <= 1'b1;
        open_row_q[bank] <= cmd_row;
      end
      occ_q <= occ_d;
      if (req && !legal) bad_op_q <= 1'b1;
      if (req && legal && !push) overflow_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ddr_cmd_queue.sv
// tb_ddr_cmd_queue: decode table, flow-control corner sequences and random traffic against a queue-based model
module tb_ddr_cmd_queue;
  logic        clock_t = 1'b0, reset_t, act_cmd, cmd_ready;
  logic [28:0] in_addr;
  logic [63:0] in_data;
  logic [1:0]  in_rw;
  logic        next_cmd, dev_busy, cmd_valid, cmd_row_hit, overflow, bad_op;
  logic [1:0]  cmd_rw, cmd_bg, cmd_ba;
  logic [14:0] cmd_row;
  logic [9:0]  cmd_col;
  logic [63:0] cmd_data;
  logic [3:0]  occupancy;

  ddr_cmd_queue dut (
    .clock_t(clock_t), .reset_t(reset_t), .act_cmd(act_cmd), .in_addr(in_addr),
    .in_data(in_data), .in_rw(in_rw), .next_cmd(next_cmd), .dev_busy(dev_busy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw), .cmd_row(cmd_row),
    .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_col(cmd_col), .cmd_data(cmd_data),
    .cmd_row_hit(cmd_row_hit), .occupancy(occupancy), .overflow(overflow), .bad_op(bad_op)
  );

  always #5 clock_t = ~clock_t;

  typedef struct packed {logic [1:0] rw; logic [28:0] addr; logic [63:0] data;} ent_t;
  typedef struct {
    logic [28:0] addr; logic [1:0] rw; logic [63:0] data;
    logic [14:0] row; logic [1:0] bg, ba; logic [9:0] col; logic [63:0] edata; logic hit;
  } vec_t;

  ent_t        q[$];
  bit          ov[16];
  int          orow[16];
  int          init_cnt;
  bit          run, m_busy, m_nc, m_ovf, m_bad;
  int          n_vec = 0, n_err = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int row_of(logic [28:0] a); return int'(a) / 16384; endfunction
  function automatic int bank_of(logic [28:0] a); return (int'(a) / 1024) % 16; endfunction

  // Model advances one clock using the inputs currently applied
  task automatic model_edge();
    bit pop, push;
    ent_t e;
    if (reset_t) begin
      q.delete();
      foreach (ov[k]) begin ov[k] = 0; orow[k] = 0; end
      init_cnt = 0; run = 0; m_busy = 1; m_nc = 0; m_ovf = 0; m_bad = 0;
    end else begin
      pop  = q.size() > 0 && cmd_ready;
      push = 0;
      if (run && act_cmd) begin
        if (in_rw != 2'b01 && in_rw != 2'b10) m_bad = 1;
        else if (q.size() < 8 || pop) push = 1;
        else m_ovf = 1;
      end
      if (pop) begin
        e = q.pop_front();
        ov[bank_of(e.addr)]   = 1;
        orow[bank_of(e.addr)] = row_of(e.addr);
      end
      if (push) begin
        e.rw = in_rw; e.addr = in_addr; e.data = (in_rw == 2'b01) ? 64'd0 : in_data;
        q.push_back(e);
      end
      m_nc = run && q.size() <= 6;
      if (!run) begin
        init_cnt++;
        if (init_cnt == 100) begin run = 1; m_busy = 0; end
      end
    end
  endtask

  task automatic check_all();
    ent_t e;
    chk("dev_busy", dev_busy, m_busy);
    chk("next_cmd", next_cmd, m_nc);
    chk("cmd_valid", cmd_valid, q.size() > 0);
    chk("occupancy", occupancy, q.size());
    chk("overflow", overflow, m_ovf);
    chk("bad_op", bad_op, m_bad);
    if (q.size() > 0) begin
      e = q[0];
      chk("cmd_rw", cmd_rw, e.rw);
      chk("cmd_row", cmd_row, row_of(e.addr));
      chk("cmd_bg", cmd_bg, bank_of(e.addr) / 4);
      chk("cmd_ba", cmd_ba, bank_of(e.addr) % 4);
      chk("cmd_col", cmd_col, int'(e.addr) % 1024);
      chk("cmd_data", cmd_data, e.data);
      chk("cmd_row_hit", cmd_row_hit, ov[bank_of(e.addr)] && orow[bank_of(e.addr)] == row_of(e.addr));
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clock_t);
    #1;
    check_all();
  endtask

  task automatic check_reset_values();
    chk("rst_dev_busy", dev_busy, 1);
    chk("rst_next_cmd", next_cmd, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_bad_op", bad_op, 0);
    chk("rst_data_outs", {cmd_rw, cmd_row, cmd_bg, cmd_ba, cmd_col, cmd_row_hit}, 0);
    chk("rst_cmd_data", cmd_data, 0);
  endtask

  task automatic wait_init();
    for (int i = 0; i < 150 && dev_busy; i++) step();
    chk("init_done", dev_busy, 0);
  endtask

  initial begin
    vec_t tv[7];
    int   busy_n;
    logic [14:0] rrow;
    logic [3:0]  rbank;
    int   r;
    tv[0] = '{29'h0ABC_D123, 2'b01, 64'h5555, 15'h2AF3, 2'd1, 2'd0, 10'h123, 64'd0, 1'b0};
    tv[1] = '{29'h0ABC_D045, 2'b01, 64'h0,    15'h2AF3, 2'd1, 2'd0, 10'h045, 64'd0, 1'b1};
    tv[2] = '{29'h0ABC_9123, 2'b10, 64'hDEAD_BEEF_0123_4567, 15'h2AF2, 2'd1, 2'd0, 10'h123, 64'hDEAD_BEEF_0123_4567, 1'b0};
    tv[3] = '{29'h0ABC_9123, 2'b01, 64'hFFFF, 15'h2AF2, 2'd1, 2'd0, 10'h123, 64'd0, 1'b1};
    tv[4] = '{29'h1FFF_FFFF, 2'b10, 64'h1,    15'h7FFF, 2'd3, 2'd3, 10'h3FF, 64'h1, 1'b0};
    tv[5] = '{29'h0000_0000, 2'b01, 64'h0,    15'h0000, 2'd0, 2'd0, 10'h000, 64'd0, 1'b0};
    tv[6] = '{29'h0ABC_9000, 2'b01, 64'h0,    15'h2AF2, 2'd1, 2'd0, 10'h000, 64'd0, 1'b1};
    reset_t = 1; act_cmd = 0; cmd_ready = 0; in_addr = '0; in_data = '0; in_rw = 2'b01;
    step();
    check_reset_values();
    busy_n = int'(dev_busy);
    reset_t = 0; act_cmd = 1;
    for (int i = 0; i < 150 && dev_busy; i++) begin
      step();
      busy_n += int'(dev_busy);
    end
    chk("busy_cycles", busy_n, 100);
    chk("init_ignores_act", occupancy, 0);
    chk("next_cmd_lag", next_cmd, 0);
    act_cmd = 0;
    step();
    chk("next_cmd_up", next_cmd, 1);

    cmd_ready = 1;
    for (int i = 0; i < 7; i++) begin
      act_cmd = 1; in_addr = tv[i].addr; in_rw = tv[i].rw; in_data = tv[i].data;
      step();
      chk("tv_valid", cmd_valid, 1);
      chk("tv_occ", occupancy, 1);
      chk("tv_rw", cmd_rw, tv[i].rw);
      chk("tv_row", cmd_row, tv[i].row);
      chk("tv_bg", cmd_bg, tv[i].bg);
      chk("tv_ba", cmd_ba, tv[i].ba);
      chk("tv_col", cmd_col, tv[i].col);
      chk("tv_data", cmd_data, tv[i].edata);
      chk("tv_hit", cmd_row_hit, tv[i].hit);
      act_cmd = 0;
      step();
    end

    cmd_ready = 0; act_cmd = 1; in_rw = 2'b10;
    for (int i = 1; i <= 8; i++) begin
      in_addr = 29'($urandom); in_data = {$urandom, $urandom};
      step();
      if (i == 6) chk("nc_at_6", next_cmd, 1);
      if (i == 7) chk("nc_at_7", next_cmd, 0);
    end
    chk("full_occ", occupancy, 8);
    cmd_ready = 1;
    step();
    chk("full_pushpop_occ", occupancy, 8);
    chk("full_pushpop_ovf", overflow, 0);
    cmd_ready = 0;
    step();
    chk("overflow_set", overflow, 1);
    chk("overflow_occ", occupancy, 8);
    in_rw = 2'b11;
    step();
    chk("bad_op_set", bad_op, 1);
    chk("bad_op_occ", occupancy, 8);
    act_cmd = 0; cmd_ready = 1;
    repeat (3) step();
    chk("five_left", occupancy, 5);
    reset_t = 1; act_cmd = 1; in_rw = 2'b01;
    step();
    check_reset_values();
    reset_t = 0; act_cmd = 0;
    wait_init();

    for (int i = 0; i < 3000; i++) begin
      reset_t = (i % 1000 == 999);
      r = int'($urandom_range(0, 3));
      rrow = (r == 0) ? 15'h2AF3 : (r == 1) ? 15'h0001 : (r == 2) ? 15'h7FFF : 15'($urandom);
      rbank = 4'($urandom_range(0, 3));
      in_addr = {rrow, rbank, 10'($urandom)};
      in_data = {$urandom, $urandom};
      r = int'($urandom_range(0, 15));
      in_rw = (r == 0) ? 2'b11 : (r == 1) ? 2'b00 : r[0] ? 2'b01 : 2'b10;
      act_cmd = $urandom_range(0, 3) != 0;
      cmd_ready = ((i / 200) % 2 == 1) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
